// File: rtl/unpacked_array_loader_if.sv
// unpacked_array_loader_if: load stream, status and indexed read bus of the table loader
interface unpacked_array_loader_if #(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int W  = 32
);
  localparam int IW = D0 > 1 ? $clog2(D0) : 1;
  localparam int JW = D1 > 1 ? $clog2(D1) : 1;
  localparam int KW = D2 > 1 ? $clog2(D2) : 1;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          load_done;
  logic          rd_en;
  logic [IW-1:0] rd_i;
  logic [JW-1:0] rd_j;
  logic [KW-1:0] rd_k;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_err;
  modport master (
    output start, in_valid, in_data, rd_en, rd_i, rd_j, rd_k,
    input  in_ready, load_done, rd_valid, rd_data, rd_err
  );
  modport slave (
    input  start, in_valid, in_data, rd_en, rd_i, rd_j, rd_k,
    output in_ready, load_done, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/unpacked_array_loader.sv
// unpacked_array_loader: streams words into a D0xD1xD2 table in assignment-pattern order with a registered indexed read port
module unpacked_array_loader #(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int W  = 32
) (
  input logic clk,
  input logic rst,
  unpacked_array_loader_if.slave bus
);
  localparam int IW = D0 > 1 ? $clog2(D0) : 1;
  localparam int JW = D1 > 1 ? $clog2(D1) : 1;
  localparam int KW = D2 > 1 ? $clog2(D2) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(D0 - 1);
  localparam logic [JW-1:0] J_TOP = JW'(D1 - 1);
  localparam logic [KW-1:0] K_TOP = KW'(D2 - 1);
  localparam logic [IW:0] I_LIM = (IW + 1)'(D0);
  localparam logic [JW:0] J_LIM = (JW + 1)'(D1);
  localparam logic [KW:0] K_LIM = (KW + 1)'(D2);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0]    state;
  logic [IW-1:0] ci;
  logic [JW-1:0] cj;
  logic [KW-1:0] ck;
  logic [W-1:0]  mem [D0-1:0][D1-1:0][D2-1:0];
  logic          acc;
  logic          last;
  logic          oor;
  assign bus.in_ready  = state == LOAD;
  assign bus.load_done = state == FULL;
  assign acc  = bus.in_valid && state == LOAD && !bus.start;
  assign last = ci == '0 && cj == '0 && ck == '0;
  assign oor  = {1'b0, bus.rd_i} >= I_LIM || {1'b0, bus.rd_j} >= J_LIM || {1'b0, bus.rd_k} >= K_LIM;
  // Fill sequencing: k counts down fastest, then j, then i; the final beat parks the counters in FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      ci    <= I_TOP;
      cj    <= J_TOP;
      ck    <= K_TOP;
      for (int a = 0; a < D0; a++)
        for (int b = 0; b < D1; b++)
          for (int c = 0; c < D2; c++)
            mem[a][b][c] <= '0;
    end else if (bus.start) begin
      state <= LOAD;
      ci    <= I_TOP;
      cj    <= J_TOP;
      ck    <= K_TOP;
    end else if (acc) begin
      mem[ci][cj][ck] <= bus.in_data;
      if (last) begin
        state <= FULL;
      end else begin
        ck <= ck == '0 ? K_TOP : ck - KW'(1);
        cj <= ck != '0 ? cj : (cj == '0 ? J_TOP : cj - JW'(1));
        ci <= (ck == '0 && cj == '0) ? ci - IW'(1) : ci;
      end
    end
  end
  // Read port: one-cycle latency, old contents on same-cycle write, zero data on bad index
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_err   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_err  <= oor;
        bus.rd_data <= oor ? '0 : mem[bus.rd_i][bus.rd_j][bus.rd_k];
      end
    end
  end
endmodule

// File: tb/tb_unpacked_array_loader.sv
// tb_unpacked_array_loader: directed table-driven checks of load order, flow control, restart and read port
module tb_unpacked_array_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cmp = 0;
  int errs = 0;
  always #5 clk = ~clk;
  unpacked_array_loader_if #(.D0(2), .D1(3), .D2(4), .W(32)) bus ();
  unpacked_array_loader #(.D0(2), .D1(3), .D2(4), .W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  typedef struct {
    int          i;
    int          j;
    int          k;
    logic [31:0] d;
    logic        e;
  } rv_t;
  rv_t tbl [7];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input int n);
    return 32'((n / 12) * 100 + ((n / 4) % 3) * 10 + n % 4);
  endfunction
  function automatic int pos(input int i, input int j, input int k);
    return (1 - i) * 12 + (2 - j) * 4 + (3 - k);
  endfunction
  task automatic rd(input int i, input int j, input int k, input logic [31:0] d, input logic e, input string nm);
    bus.rd_en = 1'b1;
    bus.rd_i  = 1'(i);
    bus.rd_j  = 2'(j);
    bus.rd_k  = 2'(k);
    tick();
    bus.rd_en = 1'b0;
    chk({nm, " valid"}, 32'(bus.rd_valid), 1);
    chk({nm, " data"}, bus.rd_data, d);
    chk({nm, " err"}, 32'(bus.rd_err), 32'(e));
  endtask
  task automatic send(input logic [31:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("send timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic run_table(input string nm);
    foreach (tbl[t]) rd(tbl[t].i, tbl[t].j, tbl[t].k, tbl[t].d, tbl[t].e, $sformatf("%s[%0d]", nm, t));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tbl[0] = '{0, 0, 2, 32'd121, 1'b0};
    tbl[1] = '{0, 1, 3, 32'd110, 1'b0};
    tbl[2] = '{1, 2, 1, 32'd2,   1'b0};
    tbl[3] = '{1, 0, 3, 32'd20,  1'b0};
    tbl[4] = '{0, 0, 0, 32'd123, 1'b0};
    tbl[5] = '{1, 2, 3, 32'd0,   1'b0};
    tbl[6] = '{1, 3, 0, 32'd0,   1'b1};
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.rd_en = 1'b0; bus.rd_i = '0; bus.rd_j = '0; bus.rd_k = '0;
    do_reset();
    chk("rst in_ready", 32'(bus.in_ready), 1);
    chk("rst load_done", 32'(bus.load_done), 0);
    chk("rst rd_valid", 32'(bus.rd_valid), 0);
    chk("rst rd_data", bus.rd_data, 0);
    chk("rst rd_err", 32'(bus.rd_err), 0);
    for (int n = 0; n < 24; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = ref_word(n);
      if (n == 23) chk("done before last", 32'(bus.load_done), 0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("done after 24", 32'(bus.load_done), 1);
    chk("ready after 24", 32'(bus.in_ready), 0);
    run_table("ref");
    do_reset();
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(ref_word(n));
    end
    chk("gap ready", 32'(bus.in_ready), 0);
    chk("gap done", 32'(bus.load_done), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd999;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    run_table("gap");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart done", 32'(bus.load_done), 0);
    chk("restart ready", 32'(bus.in_ready), 1);
    for (int n = 0; n < 5; n++) send(32'(1000 + n));
    rd(1, 0, 3, 32'd20, 1'b0, "mid restart");
    for (int n = 5; n < 24; n++) send(32'(1000 + n));
    chk("restart full", 32'(bus.load_done), 1);
    rd(1, 2, 3, 32'd1000, 1'b0, "restart first");
    rd(0, 0, 0, 32'd1023, 1'b0, "restart last");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 7; n++) send(32'(2000 + n));
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd2007;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    send(32'd2100);
    rd(1, 2, 3, 32'd2100, 1'b0, "collide next");
    rd(1, 1, 0, 32'd1007, 1'b0, "collide dropped");
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd555;
    rd(1, 2, 3, 32'd0, 1'b0, "rbw old");
    bus.in_valid = 1'b0;
    rd(1, 2, 3, 32'd555, 1'b0, "rbw new");
    tick();
    chk("idle rd_valid", 32'(bus.rd_valid), 0);
    chk("idle rd_data hold", bus.rd_data, 32'd555);
    for (int n = 1; n < 10; n++) send(ref_word(n));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ready", 32'(bus.in_ready), 1);
    chk("midrst done", 32'(bus.load_done), 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 4; k++)
          rd(i, j, k, 32'd0, 1'b0, $sformatf("midrst p%0d", pos(i, j, k)));
    send(32'd777);
    rd(1, 2, 3, 32'd777, 1'b0, "midrst first");
    rd(1, 2, 2, 32'd0, 1'b0, "midrst second");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/unpacked_array_loader.md
Name: unpacked_array_loader

Overview:
- Writer counterpart of the constant 3-D int lookup table.
- Accepts a serial stream of words over a valid/ready handshake and fills a D0 x D1 x D2 storage array in SystemVerilog assignment-pattern order.
- Exposes an indexed, registered read port, so a table can be loaded at run time and read exactly like a parameter array P[D0-1:0][D1-1:0][D2-1:0].

Parameters:
- D0, 2, size of outer dimension (index range D0-1 down to 0)
- D1, 3, size of middle dimension
- D2, 4, size of inner dimension
- W, 32, element width in bits (int)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  restart load sequence from first element
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word
- in_data  in  W  input word
- load_done  out  1  all N = D0*D1*D2 words stored
- rd_en  in  1  read request
- rd_i  in  max(1,$clog2(D0))  outer index
- rd_j  in  max(1,$clog2(D1))  middle index
- rd_k  in  max(1,$clog2(D2))  inner index
- rd_valid  out  1  rd_data/rd_err valid
- rd_data  out  W  read element
- rd_err  out  1  index out of range

Behaviour:
- Reset (rst=1 at posedge):
  - all array elements cleared to 0
  - state=LOAD, element counter=0
  - in_ready=1, load_done=0, rd_valid=0, rd_data=0, rd_err=0
- Fill order matches the assignment pattern for descending ranges; the leftmost (first) word goes to the highest indices:
  - word 0 -> [D0-1][D1-1][D2-1]
  - word 1 -> [D0-1][D1-1][D2-2]
  - ...
  - word N-1 -> [0][0][0]
  - k decrements fastest, then j, then i.
- Counter implementation: use either nested i/j/k down-counters or a linear counter with index decode; both must give the same order.
- States:
  - LOAD: in_ready=1. A beat is accepted when in_valid && in_ready. The accepted word is written at the current position and the counter advances. The N-th accepted beat moves to FULL on the same edge.
  - FULL: in_ready=0, load_done=1. in_valid is ignored. Contents are held.
- start (any state): next cycle state=LOAD, counter=0, load_done=0, in_ready=1. Array contents are retained until overwritten.
- start and an accepted beat in the same cycle: start wins, the beat is discarded (not written), counter=0.
- in_ready and load_done are registered, i.e. pure functions of state.
- Read port:
  - 1-cycle latency: rd_en sampled at edge t; rd_valid, rd_data, rd_err are updated at edge t+1.
  - rd_en=0 gives rd_valid=0 next cycle; rd_data holds its last value.
  - Out-of-range index (rd_i>=D0, rd_j>=D1 or rd_k>=D2): rd_err=1, rd_data=0.
  - Reads are legal in any state. During LOAD they return the current stored value.
  - Read and write to the same element in the same cycle: read returns the old value (read-before-write).
- Reset mid-load: array cleared, counter restarts. No partial state survives.
- No arithmetic overflow: the counter saturates by the state change to FULL and never wraps while in FULL.

Test Plan:
- Reference table load: after reset, stream 0,1,2,3,10,11,12,13,20,21,22,23,100,...,103,110,...,113,120,...,123 with in_valid=1 every cycle. Required: load_done=1 one cycle after the 24th beat. Reads must return:
  - [0][0][2] -> 121
  - [0][1][3] -> 110
  - [1][2][1] -> 2
  - [1][0][3] -> 20
- Backpressure and gaps: same stream with random in_valid gaps -> identical contents. in_ready=0 after 24 beats; a 25th word (999) is not written, and [0][0][0] stays 123.
- Restart: after a full load, pulse start and stream 24 words 1000+n. Required:
  - load_done drops the cycle after start
  - [1][2][3]=1000, [0][0][0]=1023
  - mid-stream (after 5 words), [1][0][3] still 20
- start collides with a beat: start asserted in the same cycle as word 7. Word 7 is not written and the next word lands at [1][2][3].
- Read edge cases:
  - rd_j=3 -> rd_err=1, rd_data=0, rd_valid=1 one cycle later
  - read [1][2][3] in the same cycle it is written 555 (old value 0) -> returns 0; the following read returns 555
- Reset mid-load: assert rst after 10 beats. All reads return 0, in_ready=1, load_done=0, and the next word goes to [1][2][3].
